// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch/sequencing stage: widths, PC-select
// encodings, FSM states and control-word field offsets.
package instr_fetch_seq_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned PSEL_W  = 2;

  localparam logic [PSEL_W-1:0] PSEL_HOLD = PSEL_W'(0);
  localparam logic [PSEL_W-1:0] PSEL_INC  = PSEL_W'(1);
  localparam logic [PSEL_W-1:0] PSEL_BRK  = PSEL_W'(2);
  localparam logic [PSEL_W-1:0] PSEL_REG  = PSEL_W'(3);

  localparam logic [ADDR_W-1:0] PC_RESET_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fsm_e;

  // Control-word layout: Psel occupies the top two bits of the 31-bit word
  localparam int unsigned CW_W        = 31;
  localparam int unsigned CW_PSEL_LSB = 29;
  localparam int unsigned CW_PSEL_MSB = CW_PSEL_LSB + PSEL_W - 1;

  function automatic logic [PSEL_W-1:0] cw_psel(input logic [CW_W-1:0] cw);
    return cw[CW_PSEL_MSB:CW_PSEL_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Fetch-stage bus: instruction memory handshake, decoder feedback and decoder inputs.
interface instr_fetch_seq_if;
  import instr_fetch_seq_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic [PSEL_W-1:0]  Psel;
  logic [STATE_W-1:0] nextState;
  logic [ADDR_W-1:0]  k_offset;
  logic [ADDR_W-1:0]  reg_target;
  logic [INSTR_W-1:0] instruction;
  logic [STATE_W-1:0] state;
  logic [ADDR_W-1:0]  pc;
  logic               exec_valid;

  modport master (
    output imem_req, imem_addr, instruction, state, pc, exec_valid,
    input  imem_rdata, imem_valid, Psel, nextState, k_offset, reg_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, state, pc, exec_valid,
    output imem_rdata, imem_valid, Psel, nextState, k_offset, reg_target
  );

endinterface

// File: rtl/instr_fetch_seq_pc_next.sv
// Next-PC selection: hold, +4, word-offset branch, or register target (mod 2^64).
module instr_fetch_seq_pc_next
  import instr_fetch_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [PSEL_W-1:0] psel,
  input  logic [ADDR_W-1:0] k_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc_nxt_c
);

  // The word offset's top two bits fall off the shift
  logic [ADDR_W-1:0] k_bytes;
  assign k_bytes = {k_offset[ADDR_W-3:0], 2'b00};

  always_comb begin
    pc_nxt_c = pc;
    case (psel)
      PSEL_HOLD: pc_nxt_c = pc;
      PSEL_INC:  pc_nxt_c = pc + ADDR_W'(4);
      PSEL_BRK:  pc_nxt_c = pc + k_bytes;
      PSEL_REG:  pc_nxt_c = reg_target;
      default:   pc_nxt_c = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch and sequencing: owns PC, instruction register and micro-state,
// fetches over a req/valid handshake and steps micro-states from decoder feedback.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input logic                clock,
  input logic                reset_n,
  instr_fetch_seq_if.master  bus
);

  fsm_e               fsm;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [STATE_W-1:0] state_q;
  logic               req_q;
  logic               exec_q;
  logic [ADDR_W-1:0]  pc_nxt_c;

  instr_fetch_seq_pc_next u_pc_next (
    .pc         (pc_q),
    .psel       (bus.Psel),
    .k_offset   (bus.k_offset),
    .reg_target (bus.reg_target),
    .pc_nxt_c   (pc_nxt_c)
  );

  // Sequencer: IDLE -> FETCH (wait for valid) -> EXEC (one edge per micro-state)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm     <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      state_q <= '0;
      req_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          fsm   <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            state_q <= '0;
            req_q   <= 1'b0;
            exec_q  <= 1'b1;
            fsm     <= EXEC;
          end
        end
        EXEC: begin
          pc_q    <= pc_nxt_c;
          state_q <= bus.nextState;
          if (bus.nextState == '0) begin
            fsm    <= FETCH;
            req_q  <= 1'b1;
            exec_q <= 1'b0;
          end
        end
        default: begin
          fsm    <= IDLE;
          req_q  <= 1'b0;
          exec_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.state       = state_q;
  assign bus.exec_valid  = exec_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: two instances (PC_RESET 0 and 0xFFFF_FFFF_FFFF_FFFC) in
// lockstep against a behavioural model, plus directed literal expectations.
module tb_instr_fetch_seq;

  localparam logic [63:0] RST_A = 64'd0;
  localparam logic [63:0] RST_B = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  logic        valid;
  logic [31:0] rdata;
  logic [1:0]  psel;
  logic [1:0]  ns;
  logic [63:0] koff;
  logic [63:0] rtgt;

  instr_fetch_seq_if bus_a();
  instr_fetch_seq_if bus_b();

  assign bus_a.imem_valid = valid;
  assign bus_a.imem_rdata = rdata;
  assign bus_a.Psel       = psel;
  assign bus_a.nextState  = ns;
  assign bus_a.k_offset   = koff;
  assign bus_a.reg_target = rtgt;
  assign bus_b.imem_valid = valid;
  assign bus_b.imem_rdata = rdata;
  assign bus_b.Psel       = psel;
  assign bus_b.nextState  = ns;
  assign bus_b.k_offset   = koff;
  assign bus_b.reg_target = rtgt;

  instr_fetch_seq #(.PC_RESET(RST_A)) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  instr_fetch_seq #(.PC_RESET(RST_B)) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

  always #5 clock = ~clock;

  // Reference model: phase 0 = idle, 1 = fetching, 2 = executing
  int          m_phase;
  logic [31:0] m_instr;
  logic [1:0]  m_state;
  logic [63:0] m_pc [2];

  function automatic logic [63:0] model_next_pc(input logic [63:0] p);
    case (psel)
      2'd0:    return p;
      2'd1:    return p + 64'd4;
      2'd2:    return p + koff * 64'd4;
      default: return rtgt;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_instr = '0;
      m_state = '0;
      m_pc[0] = RST_A;
      m_pc[1] = RST_B;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (valid) begin
        m_instr = rdata;
        m_state = '0;
        m_phase = 2;
      end
    end else begin
      for (int k = 0; k < 2; k++) m_pc[k] = model_next_pc(m_pc[k]);
      m_state = ns;
      if (ns == 2'd0) m_phase = 1;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cmp_one(input int k, input logic req, input logic [63:0] addr, input logic ev,
                         input logic [31:0] instr, input logic [1:0] st, input logic [63:0] pc);
    logic exp_req;
    exp_req = (m_phase == 1);
    chk($sformatf("m%0d_req", k), 64'(req), 64'(exp_req));
    chk($sformatf("m%0d_exec_valid", k), 64'(ev), 64'(m_phase == 2));
    chk($sformatf("m%0d_instruction", k), 64'(instr), 64'(m_instr));
    chk($sformatf("m%0d_state", k), 64'(st), 64'(m_state));
    chk($sformatf("m%0d_pc", k), pc, m_pc[k]);
    if (exp_req) chk($sformatf("m%0d_imem_addr", k), addr, m_pc[k]);
  endtask

  task automatic compare_model();
    cmp_one(0, bus_a.imem_req, bus_a.imem_addr, bus_a.exec_valid,
            bus_a.instruction, bus_a.state, bus_a.pc);
    cmp_one(1, bus_b.imem_req, bus_b.imem_addr, bus_b.exec_valid,
            bus_b.instruction, bus_b.state, bus_b.pc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic randomize_dontcare();
    psel = 2'($urandom);
    ns   = 2'($urandom);
    koff = {$urandom, $urandom};
    rtgt = {$urandom, $urandom};
  endtask

  // Starts in a FETCH cycle; ends in the first EXEC cycle
  task automatic fetch(input int waits, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      valid = 1'b0;
      rdata = $urandom;
      randomize_dontcare();
      tick();
    end
    valid = 1'b1;
    rdata = word;
    randomize_dontcare();
    tick();
    valid = 1'b0;
  endtask

  task automatic exec_step(input logic [1:0] p, input logic [1:0] n,
                           input logic [63:0] k, input logic [63:0] r);
    valid = 1'b0;
    psel  = p;
    ns    = n;
    koff  = k;
    rtgt  = r;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc_a"}, bus_a.pc, RST_A);
    chk({tag, "_pc_b"}, bus_b.pc, RST_B);
    chk({tag, "_req"}, 64'(bus_a.imem_req), 64'd0);
    chk({tag, "_ev"}, 64'(bus_a.exec_valid), 64'd0);
    chk({tag, "_instr"}, 64'(bus_a.instruction), 64'd0);
    chk({tag, "_state"}, 64'(bus_a.state), 64'd0);
  endtask

  // Assert at a post-edge point, hold one edge, release; returns in a FETCH cycle
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    compare_model();
    check_reset_values("rnd_rst");
    valid = 1'($urandom);
    tick();
    reset_n = 1'b1;
    valid = 1'($urandom);
    rdata = $urandom;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int waits;
    int n;
    logic [1:0] nn;

    valid = 1'b0; rdata = '0; psel = '0; ns = '0; koff = '0; rtgt = '0;
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();
    chk("first_fetch_req", 64'(bus_a.imem_req), 64'd1);
    chk("first_fetch_addr_b", bus_b.imem_addr, RST_B);

    // Zero-wait memory, Psel=01, single-state instructions
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("seq_addr%0d", i), bus_a.imem_addr, 64'(i * 4));
      chk($sformatf("seq_ev_low%0d", i), 64'(bus_a.exec_valid), 64'd0);
      fetch(0, $urandom);
      chk($sformatf("seq_ev_high%0d", i), 64'(bus_a.exec_valid), 64'd1);
      exec_step(2'b01, 2'b00, '0, '0);
      if (i == 0) chk("wrap_pc_b", bus_b.pc, 64'd0);
    end

    // Two wait cycles
    cnt = 0;
    valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (bus_a.imem_req) cnt++;
      rdata = $urandom;
      tick();
      chk("wait_pc", bus_a.pc, 64'hC);
    end
    valid = 1'b1;
    rdata = 32'h9100_0421;
    if (bus_a.imem_req) cnt++;
    tick();
    valid = 1'b0;
    chk("wait_req_cycles", 64'(cnt), 64'd3);
    chk("wait_instr", 64'(bus_a.instruction), 64'h9100_0421);
    chk("wait_ev", 64'(bus_a.exec_valid), 64'd1);
    exec_step(2'b11, 2'b00, '0, 64'h100);

    // Branch by word offset, then register target
    chk("addr_100", bus_a.imem_addr, 64'h100);
    fetch(0, $urandom);
    exec_step(2'b10, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    chk("addr_brk", bus_a.imem_addr, 64'hF0);
    fetch(0, $urandom);
    exec_step(2'b11, 2'b00, '0, 64'h2000);
    chk("addr_reg", bus_a.imem_addr, 64'h2000);

    // Three-state instruction
    fetch(0, $urandom);
    chk("ms_state0", 64'(bus_a.state), 64'd0);
    exec_step(2'b00, 2'b01, '0, '0);
    chk("ms_state1", 64'(bus_a.state), 64'd1);
    chk("ms_ev1", 64'(bus_a.exec_valid), 64'd1);
    chk("ms_pc1", bus_a.pc, 64'h2000);
    exec_step(2'b00, 2'b10, '0, '0);
    chk("ms_state2", 64'(bus_a.state), 64'd2);
    chk("ms_ev2", 64'(bus_a.exec_valid), 64'd1);
    chk("ms_pc2", bus_a.pc, 64'h2000);
    exec_step(2'b01, 2'b00, '0, '0);
    chk("ms_ev_end", 64'(bus_a.exec_valid), 64'd0);
    chk("ms_req_end", 64'(bus_a.imem_req), 64'd1);
    chk("ms_pc_end", bus_a.pc, 64'h2004);

    // Reset during the second wait cycle, then a stray valid in IDLE
    valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    compare_model();
    check_reset_values("mid_rst");
    tick();
    reset_n = 1'b1;
    valid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    valid = 1'b0;
    chk("idle_pulse_instr", 64'(bus_a.instruction), 64'd0);
    chk("resume_req", 64'(bus_a.imem_req), 64'd1);
    chk("resume_addr", bus_a.imem_addr, RST_A);
    fetch(0, 32'h1234_5678);
    chk("resume_instr", 64'(bus_a.instruction), 64'h1234_5678);
    exec_step(2'b01, 2'b00, '0, '0);
    chk("resume_pc", bus_a.pc, 64'd4);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      waits = $urandom_range(0, 3);
      fetch(waits, $urandom);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        nn = (j == n - 1) ? 2'd0 : 2'($urandom_range(1, 3));
        exec_step(2'($urandom), nn, {$urandom, $urandom}, {$urandom, $urandom});
        if (nn != 2'd0 && $urandom_range(0, 29) == 0) begin
          do_reset();
          break;
        end
        if (nn == 2'd0) break;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
